// File: rtl/battleship_pkg.sv
// Shared types for the Battleship turn sequencer:
// FSM state encoding and seven-segment word codes.
package battleship_pkg;

  typedef enum logic [3:0] {
    PLACE_A,
    CHK_A,
    PLACE_B,
    CHK_B,
    TURN_A,
    APPLY_A,
    EVAL_A,
    TURN_B,
    APPLY_B,
    EVAL_B,
    WIN_A,
    WIN_B
  } state_t;

  localparam logic [2:0] BLNK = 3'd0;
  localparam logic [2:0] PLAC = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] FIRE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;
  localparam logic [2:0] WIN  = 3'd5;
  localparam logic [2:0] LOSE = 3'd6;

  function automatic logic is_setup(input state_t s);
    return (s == PLACE_A) || (s == CHK_A) ||
           (s == PLACE_B) || (s == CHK_B);
  endfunction

endpackage

// File: rtl/turn_controller_btn_edge.sv
// Button synchroniser: two-flop sync followed by
// a rising-edge detector producing a one-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  // Sync chain plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/turn_controller.sv
// Battleship central sequencer (placement, turns, game over).
// Optional turn forfeit timer enabled by TURN_TIMEOUT_EN.
module turn_controller
  import battleship_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn1_a,
  input  logic       btn1_b,
  input  logic       btn2_a,
  input  logic       btn2_b,
  input  logic       btn3_a,
  input  logic       btn3_b,
  input  logic       ok_a,
  input  logic       ok_b,
  input  logic       liv_a,
  input  logic       liv_b,
  output logic       ldr1_a,
  output logic       ldr1_b,
  output logic       ldr2_a,
  output logic       ldr2_b,
  output logic       st,
  output logic       clr_dp,
  output logic [2:0] disp_a,
  output logic [2:0] disp_b,
  output logic       turn_a
);

  logic e1a, e1b, e2a, e2b, e3a, e3b;

  btn_edge u_e1a (.clk(clk), .clr(clr), .btn(btn1_a), .pulse(e1a));
  btn_edge u_e1b (.clk(clk), .clr(clr), .btn(btn1_b), .pulse(e1b));
  btn_edge u_e2a (.clk(clk), .clr(clr), .btn(btn2_a), .pulse(e2a));
  btn_edge u_e2b (.clk(clk), .clr(clr), .btn(btn2_b), .pulse(e2b));
  btn_edge u_e3a (.clk(clk), .clr(clr), .btn(btn3_a), .pulse(e3a));
  btn_edge u_e3b (.clk(clk), .clr(clr), .btn(btn3_b), .pulse(e3b));

  state_t     state;
  state_t     nxt;
  logic       err;
  logic       n_err;
  logic       n_ldr1_a, n_ldr1_b;
  logic       n_ldr2_a, n_ldr2_b;
  logic       n_st;
  logic       n_clr_dp;
  logic       n_turn_a;
  logic [2:0] n_disp_a, n_disp_b;
  logic       tmo;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] cnt;

  // Turn timer: restarts on entry to either TURN state
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if ((nxt != state) &&
                 ((nxt == TURN_A) || (nxt == TURN_B))) begin
      cnt <= '0;
    end else if ((state == TURN_A) || (state == TURN_B)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign tmo = (cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  // Next state, next registered outputs
  always_comb begin
    nxt      = state;
    n_err    = err;
    n_ldr1_a = 1'b0;
    n_ldr1_b = 1'b0;
    n_ldr2_a = 1'b0;
    n_ldr2_b = 1'b0;
    n_clr_dp = 1'b0;
    n_st     = 1'b1;
    n_turn_a = 1'b0;
    n_disp_a = BLNK;
    n_disp_b = BLNK;
    unique case (state)
      PLACE_A: begin
        if (e1a) begin
          nxt      = CHK_A;
          n_ldr1_a = 1'b1;
        end
      end
      CHK_A:   nxt = liv_a ? PLACE_B : PLACE_A;
      PLACE_B: begin
        if (e1b) begin
          nxt      = CHK_B;
          n_ldr1_b = 1'b1;
        end
      end
      CHK_B:   nxt = liv_b ? TURN_A : PLACE_B;
      TURN_A: begin
        if (ldr2_a) begin
          nxt      = APPLY_A;
          n_ldr1_b = 1'b1;
        end else if (e2a && ok_a) begin
          n_ldr2_a = 1'b1;
          n_err    = 1'b0;
        end else begin
          if (e2a) n_err = 1'b1;
          if (tmo) nxt = TURN_B;
        end
      end
      APPLY_A: nxt = EVAL_A;
      EVAL_A:  nxt = liv_b ? TURN_B : WIN_A;
      TURN_B: begin
        if (ldr2_b) begin
          nxt      = APPLY_B;
          n_ldr1_a = 1'b1;
        end else if (e2b && ok_b) begin
          n_ldr2_b = 1'b1;
          n_err    = 1'b0;
        end else begin
          if (e2b) n_err = 1'b1;
          if (tmo) nxt = TURN_A;
        end
      end
      APPLY_B: nxt = EVAL_B;
      EVAL_B:  nxt = liv_a ? TURN_A : WIN_B;
      WIN_A, WIN_B: begin
        if (e3a || e3b) begin
          nxt      = PLACE_A;
          n_clr_dp = 1'b1;
        end
      end
      default: nxt = PLACE_A;
    endcase

    if (nxt != state) n_err = 1'b0;

    n_st = ~is_setup(nxt);
    unique case (nxt)
      PLACE_A, CHK_A: begin
        n_disp_a = PLAC;
        n_disp_b = WAIT;
      end
      PLACE_B, CHK_B: begin
        n_disp_a = WAIT;
        n_disp_b = PLAC;
      end
      TURN_A: begin
        n_turn_a = 1'b1;
        n_disp_a = n_err ? ERR : FIRE;
        n_disp_b = WAIT;
      end
      APPLY_A, EVAL_A: begin
        n_disp_a = FIRE;
        n_disp_b = WAIT;
      end
      TURN_B: begin
        n_disp_a = WAIT;
        n_disp_b = n_err ? ERR : FIRE;
      end
      APPLY_B, EVAL_B: begin
        n_disp_a = WAIT;
        n_disp_b = FIRE;
      end
      WIN_A: begin
        n_disp_a = WIN;
        n_disp_b = LOSE;
      end
      WIN_B: begin
        n_disp_a = LOSE;
        n_disp_b = WIN;
      end
      default: begin
        n_disp_a = BLNK;
        n_disp_b = BLNK;
      end
    endcase
  end

  // State and Moore output registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= PLACE_A;
      err    <= 1'b0;
      ldr1_a <= 1'b0;
      ldr1_b <= 1'b0;
      ldr2_a <= 1'b0;
      ldr2_b <= 1'b0;
      st     <= 1'b0;
      clr_dp <= 1'b1;
      disp_a <= PLAC;
      disp_b <= WAIT;
      turn_a <= 1'b0;
    end else begin
      state  <= nxt;
      err    <= n_err;
      ldr1_a <= n_ldr1_a;
      ldr1_b <= n_ldr1_b;
      ldr2_a <= n_ldr2_a;
      ldr2_b <= n_ldr2_b;
      st     <= n_st;
      clr_dp <= n_clr_dp;
      disp_a <= n_disp_a;
      disp_b <= n_disp_b;
      turn_a <= n_turn_a;
    end
  end

endmodule

// File: doc/turn_controller.md
# turn_controller

Central sequencer for a two-player Battleship game: drives the load enables, ship/attack mux select and seven-segment word selects of both player datapaths (A and B). Takes the two boards' confirm/fire/restart buttons, the per-player attack validity and alive flags, and steps the game through placement, alternating turns, hit application and game over. Sits on the master board, between the button inputs and the two player datapath instances.

## Interface
- TIMEOUT_CYCLES, 500_000_000, turn length in clocks before forfeit (used only with TURN_TIMEOUT_EN)
- clk  in  1  system clock; all logic on rising edge
- clr  in  1  synchronous, active-high reset
- btn1_a / btn1_b  in  1  confirm ship placement (debounced, level)
- btn2_a / btn2_b  in  1  fire (debounced, level)
- btn3_a / btn3_b  in  1  restart after game over (debounced, level)
- ok_a / ok_b  in  1  player's pending attack selects exactly one new cell
- liv_a / liv_b  in  1  player still has ≥1 ship cell
- ldr1_a / ldr1_b  out  1  one-cycle load of ship register
- ldr2_a / ldr2_b  out  1  one-cycle load of attack register
- st  out  1  ship-register mux select: 0 = switches (placement), 1 = surviving ships
- clr_dp  out  1  datapath register clear
- disp_a / disp_b  out  3  word select per board
- turn_a  out  1  1 while A is to fire

## Operation
- Word codes: 0 BLNK, 1 PLAC, 2 WAIT, 3 FIRE, 4 ERR, 5 WIN, 6 LOSE; 7 unused.
- Buttons pass through 2-flop sync and rising-edge detect; only edges act. Holding a button triggers once.
- States: PLACE_A, CHK_A, PLACE_B, CHK_B, TURN_A, APPLY_A, EVAL_A, TURN_B, APPLY_B, EVAL_B, WIN_A, WIN_B.
- PLACE_A (A=PLAC, B=WAIT, st=0): btn1_a edge → ldr1_a pulse, CHK_A. CHK_A: liv_a=1 → PLACE_B; else PLACE_A (empty layout rejected). PLACE_B/CHK_B mirror, then TURN_A.
- TURN_A (A=FIRE, B=WAIT, st=1, turn_a=1): btn2_a edge with ok_a=1 → ldr2_a pulse, APPLY_A; with ok_a=0 → stay, disp_a=ERR until next btn2_a edge.
- APPLY_A: ldr1_b pulse (B ship register takes surviving cells) → EVAL_A.
- EVAL_A: liv_b=0 → WIN_A (A=WIN, B=LOSE); else TURN_B. B-side states mirror with roles swapped.
- WIN_x: btn3 edge from either board → clr_dp one-cycle pulse, PLACE_A.
- Presses by the player not in turn, and btn1/btn3 outside their states, are ignored.
- Simultaneous btn2_a and btn2_b edges: only the player in turn acts.

## Timing
- All outputs registered (Moore). Reset values: state PLACE_A, ldr*=0, st=0, clr_dp=1, disp_a=PLAC, disp_b=WAIT, turn_a=0; clr_dp drops 1 cycle after clr deasserts.
- Button level high sampled at edge k → ldr pulse high during cycle after edge k+2; width exactly 1 cycle.
- Fire to next turn: ldr2 → ldr1 (other) → EVAL → TURN, 1 cycle each; liv_* sampled in EVAL, 1 cycle after ship register load.
- ldr1_* and ldr2_* never high in the same cycle; st stable at 1 from TURN_A onward until restart.
- clr mid-game: next edge returns to reset values regardless of state; sync/edge flops cleared.

## Configuration
- TURN_TIMEOUT_EN defined: counter clears on entry to TURN_A/TURN_B; reaching TIMEOUT_CYCLES−1 without a valid fire moves to the opponent's TURN state with no loads (forfeited shot). ERR does not reset the counter.
- Undefined: no counter; a turn waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- battleship_pkg: state enum, word-code localparams (BLNK…LOSE).
- Sub-module btn_edge: 2-flop sync + rising-edge pulse, with clr; six instances.

## Test plan
- Reset then btn1_a with liv_a=0 → ldr1_a pulse, returns to PLACE_A; repeat with liv_a=1 → PLACE_B, disp_b=PLAC.
- Both placed, btn2_a with ok_a=0 → no ldr2_a, disp_a=4; then ok_a=1 press → ldr2_a, next cycle ldr1_b, then turn_a=0, disp_b=3.
- EVAL_B with liv_a=0 → disp_a=6, disp_b=5; btn3_a → clr_dp pulse, disp_a=1.
- btn2_b held 10 cycles during TURN_A then TURN_B → single ldr2_b pulse only after turn passes.
- clr asserted in APPLY_A → next cycle all ldr=0, st=0, clr_dp=1, state PLACE_A.
- TURN_TIMEOUT_EN, TIMEOUT_CYCLES=8: no fire in TURN_A → TURN_B after 8 cycles, no ldr pulses.
